// File: rtl/wm_pkg.sv
// wm_pkg: shared command codes, status bits, state and program encodings
package wm_pkg;
   localparam logic [2:0] CMD_NOP   = 3'd0;
   localparam logic [2:0] CMD_FILL  = 3'd1;
   localparam logic [2:0] CMD_WASH  = 3'd2;
   localparam logic [2:0] CMD_RINSE = 3'd3;
   localparam logic [2:0] CMD_SPIN  = 3'd4;
   localparam logic [2:0] CMD_DRAIN = 3'd5;
   localparam logic [2:0] CMD_STOP  = 3'd6;

   localparam int ST_BUSY  = 0;
   localparam int ST_DONE  = 1;
   localparam int ST_FAULT = 7;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STOP} seq_state_t;
   typedef enum logic [1:0] {PROG_NORMAL, PROG_HEAVY, PROG_QUICK, PROG_SPIN} prog_t;
endpackage

// File: rtl/wm_cmd_sequencer_if.sv
// wm_cmd_sequencer_if: command/status link between sequencer and washer core
interface wm_cmd_sequencer_if;
   logic [2:0] ctrl;
   logic [7:0] data_in;
   logic [7:0] status;
   logic [7:0] data_out;
   modport master (output ctrl, output data_in, input status, input data_out);
   modport slave (input ctrl, input data_in, output status, output data_out);
endinterface

// File: rtl/wm_step_rom.sv
// wm_step_rom: step tables mapping (program, phase) to command, operand and last-step flag
module wm_step_rom
   import wm_pkg::*;
#(
   parameter logic [7:0] D_FILL  = 8'd20,
   parameter logic [7:0] D_WASH  = 8'd120,
   parameter logic [7:0] D_RINSE = 8'd60,
   parameter logic [7:0] D_SPIN  = 8'd90,
   parameter logic [7:0] D_DRAIN = 8'd15
) (
   input  prog_t      i_prog,
   input  logic [2:0] i_phase,
   output logic [2:0] o_code,
   output logic [7:0] o_operand,
   output logic       o_last
);
   logic [8:0] w_wash_x2;
   logic [7:0] w_wash;
   assign w_wash_x2 = {D_WASH, 1'b0};
   assign w_wash = (i_prog == PROG_HEAVY) ? (w_wash_x2[8] ? 8'hFF : w_wash_x2[7:0]) :
                   (i_prog == PROG_QUICK) ? {1'b0, D_WASH[7:1]} : D_WASH;
   assign o_operand = (o_code == CMD_FILL)  ? D_FILL  :
                      (o_code == CMD_WASH)  ? w_wash  :
                      (o_code == CMD_RINSE) ? D_RINSE :
                      (o_code == CMD_SPIN)  ? D_SPIN  :
                      (o_code == CMD_DRAIN) ? D_DRAIN : 8'd0;
   // step list per program; phases past the end read as NOP/last
   always_comb begin
      o_code = CMD_NOP;
      o_last = 1'b1;
      case (i_prog)
         PROG_QUICK: begin
            case (i_phase)
               3'd0: o_code = CMD_FILL;
               3'd1: o_code = CMD_WASH;
               3'd2: o_code = CMD_DRAIN;
               3'd3: o_code = CMD_SPIN;
               default: o_code = CMD_NOP;
            endcase
            o_last = i_phase >= 3'd3;
         end
         PROG_SPIN: begin
            o_code = (i_phase == 3'd0) ? CMD_DRAIN : (i_phase == 3'd1) ? CMD_SPIN : CMD_NOP;
            o_last = i_phase >= 3'd1;
         end
         default: begin
            case (i_phase)
               3'd0: o_code = CMD_FILL;
               3'd1: o_code = CMD_WASH;
               3'd2: o_code = CMD_DRAIN;
               3'd3: o_code = CMD_RINSE;
               3'd4: o_code = CMD_DRAIN;
               3'd5: o_code = CMD_SPIN;
               default: o_code = CMD_NOP;
            endcase
            o_last = i_phase >= 3'd5;
         end
      endcase
   end
endmodule

// File: rtl/wm_cmd_sequencer.sv
// wm_cmd_sequencer: runs wash programs as phase commands with handshake, timeout and STOP recovery
module wm_cmd_sequencer
   import wm_pkg::*;
#(
   parameter int              TO_W    = 16,
   parameter logic [TO_W-1:0] TO_MAX  = 16'd50000,
   parameter logic [7:0]      D_FILL  = 8'd20,
   parameter logic [7:0]      D_WASH  = 8'd120,
   parameter logic [7:0]      D_RINSE = 8'd60,
   parameter logic [7:0]      D_SPIN  = 8'd90,
   parameter logic [7:0]      D_DRAIN = 8'd15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_start,
   input  logic [1:0]                 i_prog_sel,
   input  logic                       i_abort,
   wm_cmd_sequencer_if.master         core,
   output logic                       o_seq_busy,
   output logic                       o_seq_done,
   output logic                       o_seq_err,
   output logic [2:0]                 o_phase,
   output logic [7:0]                 o_last_resp
);
   localparam logic [TO_W-1:0] TO_LAST = TO_MAX - {{(TO_W-1){1'b0}}, 1'b1};

   seq_state_t      r_state, w_next;
   prog_t           r_prog, w_prog_nxt;
   logic [2:0]      r_phase, r_ctrl, w_phase_nxt, w_ctrl_nxt;
   logic [7:0]      r_data, r_resp, w_data_nxt, w_resp_nxt;
   logic [TO_W-1:0] r_cnt, w_cnt_nxt;
   logic            r_err, r_done, w_err_nxt, w_done_nxt;
   logic [2:0]      w_code;
   logic [7:0]      w_operand;
   logic            w_last, w_in_wait, w_accept, w_abort, w_fault, w_pdone, w_tmo;
   logic            w_unused;

   wm_step_rom #(
      .D_FILL(D_FILL), .D_WASH(D_WASH), .D_RINSE(D_RINSE), .D_SPIN(D_SPIN), .D_DRAIN(D_DRAIN)
   ) u_rom (
      .i_prog(r_prog), .i_phase(r_phase), .o_code(w_code), .o_operand(w_operand), .o_last(w_last)
   );

   assign w_unused  = ^{core.status[6:2], core.status[ST_BUSY]};
   assign w_in_wait = r_state == S_WAIT;
   assign w_accept  = (r_state == S_IDLE) & i_start;
   assign w_abort   = w_in_wait & i_abort;
   assign w_fault   = w_in_wait & ~i_abort & core.status[ST_FAULT];
   assign w_pdone   = w_in_wait & ~i_abort & ~core.status[ST_FAULT] & core.status[ST_DONE];
   assign w_tmo     = w_in_wait & ~i_abort & ~core.status[ST_FAULT] & ~core.status[ST_DONE] & (r_cnt == TO_LAST);

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_prog  <= PROG_NORMAL;
         r_phase <= 3'd0;
         r_ctrl  <= CMD_NOP;
         r_data  <= 8'd0;
         r_resp  <= 8'd0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_prog  <= w_prog_nxt;
         r_phase <= w_phase_nxt;
         r_ctrl  <= w_ctrl_nxt;
         r_data  <= w_data_nxt;
         r_resp  <= w_resp_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // next state; WAIT exits in priority abort, fault, phase_done, timeout
   always_comb begin
      w_next = (r_state == S_IDLE)  ? (i_start ? S_ISSUE : S_IDLE) :
               (r_state == S_ISSUE) ? S_WAIT :
               (r_state == S_STOP)  ? S_IDLE :
               (w_abort | w_fault | w_tmo) ? S_STOP :
               w_pdone ? (w_last ? S_IDLE : S_ISSUE) : S_WAIT;
   end

   // next values of outputs and datapath; STOP is shown in the STOP cycle itself
   always_comb begin
      w_ctrl_nxt  = (w_next == S_STOP) ? CMD_STOP : (r_state == S_ISSUE) ? w_code : CMD_NOP;
      w_data_nxt  = (r_state == S_ISSUE) ? w_operand : 8'd0;
      w_phase_nxt = w_accept ? 3'd0 : (w_pdone & ~w_last) ? r_phase + 3'd1 : r_phase;
      w_cnt_nxt   = (r_state == S_ISSUE) ? '0 : w_in_wait ? r_cnt + 1'b1 : r_cnt;
      w_err_nxt   = w_accept ? 1'b0 : (w_fault | w_tmo) ? 1'b1 : r_err;
      w_done_nxt  = w_pdone & w_last;
      w_resp_nxt  = w_pdone ? core.data_out : r_resp;
      w_prog_nxt  = w_accept ? prog_t'(i_prog_sel) : r_prog;
   end

   assign core.ctrl    = r_ctrl;
   assign core.data_in = r_data;
   assign o_seq_busy   = r_state != S_IDLE;
   assign o_seq_done   = r_done;
   assign o_seq_err    = r_err;
   assign o_phase      = r_phase;
   assign o_last_resp  = r_resp;
endmodule
